mc_muldiv: RTL and testbench

- Multicycle iterative multiply/divide unit with HI/LO result registers, attached beside the ALU in the multicycle CPU datapath.
- Adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support that the single-cycle ALU lacks.
- Control FSM asserts start for one cycle and stalls until done.
- Operand width is parametrised for reuse in narrower teaching cores.

---
 rtl/mc_pkg.sv | 19 +
 rtl/mc_muldiv_core.sv | 35 +++
 rtl/mc_muldiv.sv | 170 +++++++++++++++++
 tb/tb_mc_muldiv.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mc_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mc_muldiv_core.sv
// One iteration of the shift-add multiply or restoring shift-subtract divide.
module mc_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             mul,
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   acc_hi_nxt,
  output logic [WIDTH-1:0] acc_lo_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    // Multiply: acc_lo holds the multiplier, consumed LSB first.
    sum     = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
    // Divide: acc_lo holds the dividend, shifted out MSB first while quotient bits enter.
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {2'b00, opnd};
    if (mul) begin
      acc_hi_nxt = {1'b0, sum[WIDTH:1]};
      acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    end else if (diff[WIDTH+1]) begin
      acc_hi_nxt = shifted[WIDTH:0];
      acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
    end else begin
      acc_hi_nxt = diff[WIDTH:0];
      acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mc_muldiv.sv
// Multicycle multiply/divide unit with HI/LO registers; the first RUN cycle loads the accumulators.
module mc_muldiv
  import mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNTW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d, a_orig_q, a_orig_d;
  logic [WIDTH:0]     acc_hi_q, acc_hi_d, core_hi;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d, core_lo;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d, div0_q, div0_d, done_q, done_d;
  logic               is_mul_op, is_div_op, is_signed, sign_a, sign_b, accept;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  assign is_mul_op = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div_op = (op == MD_DIV) || (op == MD_DIVU);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign sign_a    = is_signed & a[WIDTH-1];
  assign sign_b    = is_signed & b[WIDTH-1];
  assign accept    = start && (state_q == S_IDLE);

  mc_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .mul       (!is_div_q),
    .acc_hi    (acc_hi_q),
    .acc_lo    (acc_lo_q),
    .opnd      (opb_q),
    .acc_hi_nxt(core_hi),
    .acc_lo_nxt(core_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && (is_mul_op || is_div_op)) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNTW'(WIDTH)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_comb begin
    prod = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    if (neg_res_q) prod = -prod;
    quot = neg_res_q ? -acc_lo_q : acc_lo_q;
    rem  = neg_rem_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
  end

  always_comb begin
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    a_orig_d  = a_orig_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && (is_mul_op || is_div_op)) begin
          opa_d     = sign_a ? -a : a;
          opb_d     = sign_b ? -b : b;
          a_orig_d  = a;
          is_div_d  = is_div_op;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          div0_d    = is_div_op && (b == '0);
          cnt_d     = '0;
        end else if (accept && op == MD_MTHI) begin
          hi_d   = a;
          done_d = 1'b1;
        end else if (accept && op == MD_MTLO) begin
          lo_d   = a;
          done_d = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          acc_hi_d = '0;
          acc_lo_d = opa_q;
        end else begin
          acc_hi_d = core_hi;
          acc_lo_d = core_lo;
        end
      end
      S_FIX: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod;
        end else if (div0_q) begin
          hi_d = a_orig_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      a_orig_q  <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      a_orig_q  <= a_orig_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mc_muldiv.sv
// Directed checks of mc_muldiv (WIDTH=32) against hand-computed results.
module tb_mc_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mc_muldiv #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Presents one request sampled at edge 0, then waits for done (bounded).
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output logic busy1, output logic busy_pre);
    logic prev_busy;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy1 = 1'b0; busy_pre = 1'b0; prev_busy = busy;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 1) busy1 = busy;
      if (done) begin
        lat = k;
        busy_pre = prev_busy;
        break;
      end
      prev_busy = busy;
    end
  endtask

  initial begin
    int lat, ndone;
    logic bz1, bzp;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    @(negedge clk); rst = 1'b0;

    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bz1, bzp);
    chk("multu_lat", lat, 32'd34);
    chk("multu_busy1", {31'b0, bz1}, 32'h1);
    chk("multu_busy33", {31'b0, bzp}, 32'h1);
    chk("multu_busy_dn", {31'b0, busy}, 32'h0);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    run_op(3'b000, 32'hFFFFFFFD, 32'h00000007, lat, bz1, bzp);
    chk("mult_lat", lat, 32'd34);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, lat, bz1, bzp);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);

    run_op(3'b011, 32'h00000064, 32'h00000000, lat, bz1, bzp);
    chk("divu0_lat", lat, 32'd34);
    chk("divu0_hi", hi, 32'h00000064);
    chk("divu0_lo", lo, 32'hFFFFFFFF);

    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, lat, bz1, bzp);
    chk("divmin_hi", hi, 32'h00000000);
    chk("divmin_lo", lo, 32'h80000000);

    // MTHI then MTLO on consecutive edges
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h12345678;
    @(posedge clk); #1;
    chk("mthi_done", {31'b0, done}, 32'h1);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    chk("mthi_hi", hi, 32'h12345678);
    op = 3'b101; a = 32'h9ABCDEF0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_done", {31'b0, done}, 32'h1);
    chk("mtlo_busy", {31'b0, busy}, 32'h0);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi_hold", hi, 32'h12345678);
    @(posedge clk); #1;
    chk("mt_done_clr", {31'b0, done}, 32'h0);

    // DIVU 100/7 with an ignored MULTU request mid-flight
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin start = 1'b1; op = 3'b001; a = 32'h5; b = 32'h6; end
      if (k == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
    chk("ovl_ndone", ndone, 32'd1);
    chk("ovl_lat", lat, 32'd34);
    chk("ovl_hi", hi, 32'd2);
    chk("ovl_lo", lo, 32'd14);

    // Async reset in the middle of a MULT
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'h00001234; b = 32'h00005678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_busy", {31'b0, busy}, 32'h0);
    chk("mrst_done", {31'b0, done}, 32'h0);
    chk("mrst_hi", hi, 32'h0);
    chk("mrst_lo", lo, 32'h0);
    @(negedge clk); rst = 1'b0;

    run_op(3'b001, 32'd3, 32'd5, lat, bz1, bzp);
    chk("post_lat", lat, 32'd34);
    chk("post_hi", hi, 32'h0);
    chk("post_lo", lo, 32'h0000000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
